// File: rtl/sbox_preimage_search.sv
// Inverse search for the 4-bit S1 S-box: scans candidates 0..15 through the
// forward table and streams every preimage of the requested output value,
// ascending, on a valid/ready result port. One pending hit is held back so
// that the final beat can carry m_last and the total match count.
module sbox_preimage_search #(
    parameter bit FIRST_ONLY = 1'b0
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_target,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [3:0] m_data,
    output logic       m_hit,
    output logic       m_last,
    output logic [4:0] m_count
);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, LAST} state_t;

    state_t     state_q;
    logic [3:0] target_q;
    logic [3:0] cand_q;
    logic [3:0] pend_q;
    logic       pend_v_q;
    logic [4:0] cnt_q;
    logic       m_valid_q;
    logic [3:0] m_data_q;
    logic       m_hit_q;
    logic       m_last_q;
    logic [4:0] m_count_q;

    logic       match;
    logic       out_free;

    // Forward S1 table: row = {c[0],c[3]}, col = {c[1],c[2]}
    function automatic logic [3:0] sbox_fwd(input logic [3:0] c);
        logic [3:0] idx;
        idx = {c[0], c[3], c[1], c[2]};
        case (idx)
            4'd0:    sbox_fwd = 4'd14;
            4'd1:    sbox_fwd = 4'd4;
            4'd2:    sbox_fwd = 4'd13;
            4'd3:    sbox_fwd = 4'd1;
            4'd4:    sbox_fwd = 4'd0;
            4'd5:    sbox_fwd = 4'd15;
            4'd6:    sbox_fwd = 4'd7;
            4'd7:    sbox_fwd = 4'd4;
            4'd8:    sbox_fwd = 4'd4;
            4'd9:    sbox_fwd = 4'd1;
            4'd10:   sbox_fwd = 4'd14;
            4'd11:   sbox_fwd = 4'd8;
            4'd12:   sbox_fwd = 4'd15;
            4'd13:   sbox_fwd = 4'd12;
            4'd14:   sbox_fwd = 4'd8;
            default: sbox_fwd = 4'd2;
        endcase
    endfunction

    assign match     = (sbox_fwd(cand_q) == target_q);
    assign out_free  = !m_valid_q || m_ready;

    assign req_ready = (state_q == IDLE);
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_hit     = m_hit_q;
    assign m_last    = m_last_q;
    assign m_count   = m_count_q;

    // Search FSM together with the registered result beat
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            cand_q    <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_hit_q   <= 1'b0;
            m_last_q  <= 1'b0;
            m_count_q <= '0;
        end else begin
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        target_q <= req_target;
                        cand_q   <= '0;
                        cnt_q    <= '0;
                        pend_q   <= '0;
                        pend_v_q <= 1'b0;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    if (FIRST_ONLY && match) begin
                        if (out_free) begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= cand_q;
                            m_hit_q   <= 1'b1;
                            m_last_q  <= 1'b1;
                            m_count_q <= 5'd1;
                            state_q   <= LAST;
                        end
                    end else if (cand_q == 4'hF) begin
                        // The final beat is loaded straight from the last scan
                        // step; FLUSH is only needed when candidate 15 is a hit
                        // that must queue behind a still-pending earlier hit.
                        if (out_free) begin
                            m_valid_q <= 1'b1;
                            if (match && pend_v_q) begin
                                m_data_q  <= pend_q;
                                m_hit_q   <= 1'b1;
                                m_last_q  <= 1'b0;
                                m_count_q <= '0;
                                pend_q    <= cand_q;
                                cnt_q     <= cnt_q + 5'd1;
                                state_q   <= FLUSH;
                            end else if (match) begin
                                m_data_q  <= cand_q;
                                m_hit_q   <= 1'b1;
                                m_last_q  <= 1'b1;
                                m_count_q <= cnt_q + 5'd1;
                                state_q   <= LAST;
                            end else if (pend_v_q) begin
                                m_data_q  <= pend_q;
                                m_hit_q   <= 1'b1;
                                m_last_q  <= 1'b1;
                                m_count_q <= cnt_q;
                                state_q   <= LAST;
                            end else begin
                                m_data_q  <= '0;
                                m_hit_q   <= 1'b0;
                                m_last_q  <= 1'b1;
                                m_count_q <= '0;
                                state_q   <= LAST;
                            end
                        end
                    end else if (match) begin
                        if (!pend_v_q) begin
                            pend_q   <= cand_q;
                            pend_v_q <= 1'b1;
                            cnt_q    <= cnt_q + 5'd1;
                            cand_q   <= cand_q + 4'd1;
                        end else if (out_free) begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= pend_q;
                            m_hit_q   <= 1'b1;
                            m_last_q  <= 1'b0;
                            m_count_q <= '0;
                            pend_q    <= cand_q;
                            cnt_q     <= cnt_q + 5'd1;
                            cand_q    <= cand_q + 4'd1;
                        end
                    end else begin
                        cand_q <= cand_q + 4'd1;
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= pend_q;
                        m_hit_q   <= 1'b1;
                        m_last_q  <= 1'b1;
                        m_count_q <= cnt_q;
                        state_q   <= LAST;
                    end
                end
                LAST: begin
                    if (m_valid_q && m_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_preimage_search.sv
// Directed bench for sbox_preimage_search: one full-stream instance and one
// FIRST_ONLY instance, sharing target/ready/reset, with separate req_valid.
module tb_sbox_preimage_search;

    logic       ck;
    logic       rst_n;
    logic       req_valid0;
    logic       req_valid1;
    logic [3:0] req_target;
    logic       m_ready;

    logic       req_ready0, m_valid0, m_hit0, m_last0;
    logic [3:0] m_data0;
    logic [4:0] m_count0;
    logic       req_ready1, m_valid1, m_hit1, m_last1;
    logic [3:0] m_data1;
    logic [4:0] m_count1;

    int         passed;
    int         total;
    int         fails;
    int         cyc;
    logic [3:0] fmodel [16];

    sbox_preimage_search #(.FIRST_ONLY(1'b0)) dut (
        .ck(ck), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_target(req_target), .m_valid(m_valid0), .m_ready(m_ready),
        .m_data(m_data0), .m_hit(m_hit0), .m_last(m_last0), .m_count(m_count0)
    );

    sbox_preimage_search #(.FIRST_ONLY(1'b1)) dut_fo (
        .ck(ck), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_target(req_target), .m_valid(m_valid1), .m_ready(m_ready),
        .m_data(m_data1), .m_hit(m_hit1), .m_last(m_last1), .m_count(m_count1)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
        cyc++;
    endtask

    // {valid[11], data[10:7], hit[6], last[5], count[4:0]}
    function automatic logic [11:0] outs(input int sel);
        if (sel == 0) outs = {m_valid0, m_data0, m_hit0, m_last0, m_count0};
        else          outs = {m_valid1, m_data1, m_hit1, m_last1, m_count1};
    endfunction

    function automatic logic rdy(input int sel);
        rdy = (sel == 0) ? req_ready0 : req_ready1;
    endfunction

    task automatic send(input int sel, input logic [3:0] tgt, output int acc);
        bit ok;
        logic r;
        ok = 1'b0;
        req_target = tgt;
        if (sel == 0) req_valid0 = 1'b1;
        else          req_valid1 = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            r = rdy(sel);
            step();
            if (r) ok = 1'b1;
        end
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        acc = cyc;
        chk("accept", 32'(ok), 32'd1);
    endtask

    // mode 0: m_ready=1; mode 1: random m_ready plus busy request poke;
    // mode 2: hold m_ready low 10 cycles once the first beat is valid
    task automatic run_req(input int sel, input logic [3:0] tgt, input int mode,
                           output int sum_cnt, output int first_lat, output int last_lat);
        logic [3:0]  exp_list[$];
        logic [3:0]  first;
        logic [11:0] o;
        logic [11:0] o0;
        int          acc;
        int          nb;
        int          nexp;
        bit          done;
        bit          stalled;
        bit          stable;
        bit          is_last;
        exp_list = {};
        for (int c = 0; c < 16; c++) if (fmodel[c] == tgt) exp_list.push_back(4'(c));
        if (sel == 1 && exp_list.size() > 1) begin
            first = exp_list[0];
            exp_list.delete();
            exp_list.push_back(first);
        end
        nexp = exp_list.size();
        send(sel, tgt, acc);
        m_ready   = (mode != 2);
        nb        = 0;
        done      = 1'b0;
        stalled   = 1'b0;
        sum_cnt   = 0;
        first_lat = -1;
        last_lat  = -1;
        for (int i = 0; i < 300 && !done; i++) begin
            if (mode == 1) begin
                m_ready = ($urandom_range(0, 1) != 0);
                if (i == 4) begin
                    req_target = ~tgt;
                    if (sel == 0) req_valid0 = 1'b1;
                    else          req_valid1 = 1'b1;
                end
                if (i == 5) chk("busy_req_ready", 32'(rdy(sel)), 32'd0);
                if (i == 8) begin
                    req_valid0 = 1'b0;
                    req_valid1 = 1'b0;
                end
            end
            o = outs(sel);
            if (mode == 2 && o[11] && !stalled) begin
                stalled = 1'b1;
                stable  = 1'b1;
                o0      = o;
                for (int k = 0; k < 10; k++) begin
                    step();
                    if (outs(sel) !== o0) stable = 1'b0;
                end
                chk("stall_hold", 32'(stable), 32'd1);
                chk("stall_data", 32'(o0[10:7]), (nexp > 0) ? 32'(exp_list[0]) : 32'd0);
                m_ready = 1'b1;
                o = outs(sel);
            end
            if (o[11] && m_ready) begin
                if (first_lat < 0) first_lat = cyc - acc;
                if (nexp > 0 && nb >= nexp) begin
                    chk("extra_beat", 32'd1, 32'd0);
                    done = 1'b1;
                end else begin
                    is_last = (nexp == 0) || (nb == nexp - 1);
                    chk("beat_data", 32'(o[10:7]), (nexp > 0) ? 32'(exp_list[nb]) : 32'd0);
                    chk("beat_hit", 32'(o[6]), (nexp > 0) ? 32'd1 : 32'd0);
                    chk("beat_last", 32'(o[5]), 32'(is_last));
                    chk("beat_count", 32'(o[4:0]), is_last ? 32'(nexp) : 32'd0);
                    if (o[5]) begin
                        sum_cnt  = int'(o[4:0]);
                        last_lat = cyc - acc;
                        done     = 1'b1;
                    end
                    nb++;
                end
            end
            step();
        end
        chk("request_done", 32'(done), 32'd1);
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        m_ready    = 1'b1;
    endtask

    initial begin
        int sum;
        int total_cnt;
        int fl;
        int ll;
        int acc;
        passed = 0;
        total  = 0;
        fails  = 0;
        cyc    = 0;
        fmodel = '{4'd14, 4'd4, 4'd13, 4'd14, 4'd4, 4'd1, 4'd1, 4'd8,
                   4'd0, 4'd15, 4'd7, 4'd8, 4'd15, 4'd12, 4'd4, 4'd2};
        rst_n      = 1'b0;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        req_target = '0;
        m_ready    = 1'b1;
        step();
        step();
        chk("rst_m_valid", 32'(m_valid0), 32'd0);
        chk("rst_req_ready", 32'(req_ready0), 32'd1);
        chk("rst_m_data", 32'(m_data0), 32'd0);
        chk("rst_m_hit", 32'(m_hit0), 32'd0);
        chk("rst_m_last", 32'(m_last0), 32'd0);
        chk("rst_m_count", 32'(m_count0), 32'd0);
        chk("rst_fo_m_valid", 32'(m_valid1), 32'd0);
        rst_n = 1'b1;
        step();

        // Target 4: beats 1, 4, 14
        run_req(0, 4'd4, 0, sum, fl, ll);
        chk("t4_count", 32'(sum), 32'd3);
        chk("t4_first_lat", 32'(fl), 32'd5);
        chk("t4_last_lat", 32'(ll), 32'd16);

        // Target 3: no preimage, final beat in cycle 17
        run_req(0, 4'd3, 0, sum, fl, ll);
        chk("t3_last_lat", 32'(ll), 32'd16);

        // Target 14 with downstream backpressure
        run_req(0, 4'd14, 2, sum, fl, ll);
        chk("t14_count", 32'(sum), 32'd2);

        // FIRST_ONLY target 4: single beat data=1 in cycle 3
        run_req(1, 4'd4, 0, sum, fl, ll);
        chk("fo_t4_count", 32'(sum), 32'd1);
        chk("fo_t4_lat", 32'(fl), 32'd2);
        chk("fo_idle", 32'(req_ready1), 32'd1);

        // All targets with random backpressure
        total_cnt = 0;
        for (int t = 0; t < 16; t++) begin
            run_req(0, 4'(t), 1, sum, fl, ll);
            total_cnt += sum;
        end
        chk("sum_counts", 32'(total_cnt), 32'd16);

        // Reset in the middle of a scan
        send(0, 4'd4, acc);
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid0), 32'd0);
        chk("midrst_req_ready", 32'(req_ready0), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        run_req(0, 4'd13, 0, sum, fl, ll);
        chk("t13_count", 32'(sum), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
